// File: rtl/dot_matrix_frame_buffer.sv
// Double-buffered 8x8 image store for the dot-matrix row scanner, with optional column scrolling.
// Optional blanking-blink feature is compiled in with `define DOT_MATRIX_BLINK_EN.
module dot_matrix_frame_buffer #(
  parameter logic [7:0]  SCROLL_DIV   = 8'd4,
  parameter logic [63:0] INIT_PATTERN = 64'h0,
  parameter logic [7:0]  BLINK_FRAMES = 8'd16
) (
  input  logic       clk_div,
  input  logic       rst,
  input  logic [2:0] row_sel,
  output logic [7:0] row_data,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       commit,
  output logic       commit_pending,
  input  logic       scroll_en,
  input  logic       scroll_dir,
  input  logic       blink,
  output logic       frame_tick
);

  localparam logic [7:0] SCROLL_LAST = SCROLL_DIV - 8'd1;

  logic [7:0] r_front [8];
  logic [7:0] r_back  [8];
  logic [2:0] r_row_sel_q;
  logic       r_frame_tick;
  logic       r_pending;
  logic [7:0] r_scroll_cnt;
  logic [7:0] r_row_data;

  logic       w_tick;
  logic       w_swap;
  logic       w_step;
  logic [7:0] w_row_mask;

  function automatic logic [7:0] init_row(input int idx);
    return INIT_PATTERN[63 - 8*idx -: 8];
  endfunction

  function automatic logic [7:0] rot_left(input logic [7:0] r);
    return {r[6:0], r[7]};
  endfunction

  function automatic logic [7:0] rot_right(input logic [7:0] r);
    return {r[0], r[7:1]};
  endfunction

  // Frame boundary: first cycle the scanner reaches row 7
  assign w_tick = (row_sel == 3'd7) && (r_row_sel_q != 3'd7);
  assign w_swap = w_tick && r_pending;
  assign w_step = w_tick && scroll_en && (r_scroll_cnt == SCROLL_LAST);

  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst) begin
      r_row_sel_q  <= 3'd0;
      r_frame_tick <= 1'b0;
      r_pending    <= 1'b0;
      r_scroll_cnt <= 8'd0;
    end else begin
      r_row_sel_q  <= row_sel;
      r_frame_tick <= w_tick;
      if (w_swap)
        r_pending <= 1'b0;
      else if (commit)
        r_pending <= 1'b1;
      // A swap on a step tick also lands the counter on 0, so no special case is needed
      if (!scroll_en)
        r_scroll_cnt <= 8'd0;
      else if (w_tick)
        r_scroll_cnt <= (r_scroll_cnt == SCROLL_LAST) ? 8'd0 : r_scroll_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        r_front[i] <= init_row(i);
        r_back[i]  <= init_row(i);
      end
    end else begin
      if (wr_en)
        r_back[wr_row] <= wr_data;
      // Swap takes priority over a rotation on the same tick
      for (int i = 0; i < 8; i++) begin
        if (w_swap)
          r_front[i] <= r_back[i];
        else if (w_step)
          r_front[i] <= scroll_dir ? rot_right(r_front[i]) : rot_left(r_front[i]);
      end
    end
  end

`ifdef DOT_MATRIX_BLINK_EN
  logic [7:0] r_blink_cnt;
  logic       r_blink_phase;

  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst) begin
      r_blink_cnt   <= 8'd0;
      r_blink_phase <= 1'b0;
    end else if (!blink) begin
      r_blink_cnt   <= 8'd0;
      r_blink_phase <= 1'b0;
    end else if (w_tick) begin
      if (r_blink_cnt == BLINK_FRAMES - 8'd1) begin
        r_blink_cnt   <= 8'd0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 8'd1;
      end
    end
  end

  assign w_row_mask = r_blink_phase ? 8'h00 : 8'hFF;
`else
  logic w_unused;
  assign w_unused   = ^{blink, BLINK_FRAMES};
  assign w_row_mask = 8'hFF;
`endif

  // Read stage: samples the front buffer before any same-cycle swap or rotate
  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst)
      r_row_data <= 8'h00;
    else
      r_row_data <= r_front[row_sel] & w_row_mask;
  end

  assign row_data       = r_row_data;
  assign frame_tick     = r_frame_tick;
  assign commit_pending = r_pending;

endmodule

// File: tb/tb_dot_matrix_frame_buffer.sv
// Directed bench for dot_matrix_frame_buffer: two instances (SCROLL_DIV 2 and 1) share one stimulus.
module tb_dot_matrix_frame_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] row_sel, wr_row;
  logic [7:0] wr_data;
  logic       wr_en, commit, scroll_en, scroll_dir, blink;
  logic [7:0] rd_a, rd_b;
  logic       cp_a, cp_b, ft_a, ft_b;

  dot_matrix_frame_buffer #(
    .SCROLL_DIV(8'd2), .INIT_PATTERN(64'h0102040810204080), .BLINK_FRAMES(8'd2)
  ) dut_a (
    .clk_div(clk), .rst(rst), .row_sel(row_sel), .row_data(rd_a),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .commit(commit),
    .commit_pending(cp_a), .scroll_en(scroll_en), .scroll_dir(scroll_dir),
    .blink(blink), .frame_tick(ft_a)
  );

  dot_matrix_frame_buffer #(
    .SCROLL_DIV(8'd1), .INIT_PATTERN(64'h0102040810204080), .BLINK_FRAMES(8'd2)
  ) dut_b (
    .clk_div(clk), .rst(rst), .row_sel(row_sel), .row_data(rd_b),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .commit(commit),
    .commit_pending(cp_b), .scroll_en(scroll_en), .scroll_dir(scroll_dir),
    .blink(blink), .frame_tick(ft_b)
  );

  typedef struct {
    logic [2:0] rs;
    logic [7:0] exp_d;
    logic       exp_t;
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] fa [8];
  logic [7:0] fb [8];
  vec_t       vt [10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; row_sel = 3'd0; wr_en = 1'b0; wr_row = 3'd0; wr_data = 8'h00;
    commit = 1'b0; scroll_en = 1'b0; scroll_dir = 1'b0; blink = 1'b0;
    step;
    step;
    rst = 1'b1;
  endtask

  // One full scan 0..7; optional write/commit applied in the row-0 cycle
  task automatic frame(input bit wr, input logic [2:0] wrow, input logic [7:0] wd, input bit cm);
    for (int r = 0; r < 8; r++) begin
      row_sel = 3'(r);
      wr_en   = wr && (r == 0);
      wr_row  = wrow;
      wr_data = wd;
      commit  = cm && (r == 0);
      step;
      fa[r] = rd_a;
      fb[r] = rd_b;
    end
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{3'd0, 8'h01, 1'b0};
    vt[1] = '{3'd1, 8'h02, 1'b0};
    vt[2] = '{3'd2, 8'h04, 1'b0};
    vt[3] = '{3'd3, 8'h08, 1'b0};
    vt[4] = '{3'd4, 8'h10, 1'b0};
    vt[5] = '{3'd5, 8'h20, 1'b0};
    vt[6] = '{3'd6, 8'h40, 1'b0};
    vt[7] = '{3'd7, 8'h80, 1'b1};
    vt[8] = '{3'd7, 8'h80, 1'b0};
    vt[9] = '{3'd0, 8'h01, 1'b0};

    // Reset state
    rst = 1'b0; row_sel = 3'd0; wr_en = 1'b0; wr_row = 3'd0; wr_data = 8'h00;
    commit = 1'b0; scroll_en = 1'b0; scroll_dir = 1'b0; blink = 1'b0;
    step;
    step;
    chk("reset_row_data", rd_a, 8'h00);
    chk("reset_pending", 8'(cp_a), 8'h00);
    chk("reset_tick", 8'(ft_a), 8'h00);
    rst = 1'b1;

    // Read sweep after reset, including row 7 held
    for (int i = 0; i < 10; i++) begin
      row_sel = vt[i].rs;
      step;
      chk($sformatf("sweep%0d_data", i), rd_a, vt[i].exp_d);
      chk($sformatf("sweep%0d_tick", i), 8'(ft_a), 8'(vt[i].exp_t));
    end

    // Double buffer: mid-frame write + commit
    row_sel = 3'd1; wr_en = 1'b1; wr_row = 3'd3; wr_data = 8'hFF;
    step;
    wr_en = 1'b0;
    row_sel = 3'd2; commit = 1'b1;
    step;
    commit = 1'b0;
    chk("db_pending_set", 8'(cp_a), 8'h01);
    chk("db_row2", rd_a, 8'h04);
    row_sel = 3'd3;
    step;
    chk("db_row3_old", rd_a, 8'h08);
    for (int r = 4; r < 7; r++) begin
      row_sel = 3'(r);
      step;
      chk($sformatf("db_pending_r%0d", r), 8'(cp_a), 8'h01);
    end
    row_sel = 3'd7;
    step;
    chk("db_tick", 8'(ft_a), 8'h01);
    chk("db_pending_clear", 8'(cp_a), 8'h00);
    frame(1'b0, 3'd0, 8'h00, 1'b0);
    chk("db_row3_new", fa[3], 8'hFF);
    chk("db_row2_kept", fa[2], 8'h04);

    // Commit on the tick cycle swaps only on the following tick
    for (int r = 0; r < 6; r++) begin
      row_sel = 3'(r);
      step;
    end
    row_sel = 3'd6; wr_en = 1'b1; wr_row = 3'd5; wr_data = 8'hAA;
    step;
    wr_en = 1'b0;
    row_sel = 3'd7; commit = 1'b1;
    step;
    commit = 1'b0;
    chk("tickcommit_pending", 8'(cp_a), 8'h01);
    frame(1'b0, 3'd0, 8'h00, 1'b0);
    chk("tickcommit_no_swap", fa[5], 8'h20);
    chk("tickcommit_pending_clr", 8'(cp_a), 8'h00);
    frame(1'b0, 3'd0, 8'h00, 1'b0);
    chk("tickcommit_swapped", fa[5], 8'hAA);

    // Scroll left, SCROLL_DIV=2
    do_reset;
    frame(1'b1, 3'd0, 8'h81, 1'b1);
    scroll_en = 1'b1; scroll_dir = 1'b0;
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("sl_f1", fa[0], 8'h81);
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("sl_f2", fa[0], 8'h81);
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("sl_f3", fa[0], 8'h03);
    chk("sl_f3_row7", fa[7], 8'h01);
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("sl_f4", fa[0], 8'h03);
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("sl_f5", fa[0], 8'h06);
    scroll_en = 1'b0;

    // Scroll right with wrap: B has SCROLL_DIV=1, A has 2
    do_reset;
    scroll_en = 1'b1; scroll_dir = 1'b1;
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("sr_b_f1", fb[0], 8'h01); chk("sr_a_f1", fa[0], 8'h01);
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("sr_b_f2", fb[0], 8'h80); chk("sr_a_f2", fa[0], 8'h01);
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("sr_b_f3", fb[0], 8'h40); chk("sr_a_f3", fa[0], 8'h80);
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("sr_b_f4", fb[0], 8'h20); chk("sr_a_f4", fa[0], 8'h80);
    scroll_en = 1'b0;

    // Swap landing on a scroll-step tick
    do_reset;
    scroll_en = 1'b1; scroll_dir = 1'b0;
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("col_f1", fa[0], 8'h01);
    frame(1'b1, 3'd0, 8'h30, 1'b1); chk("col_f2", fa[0], 8'h01);
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("col_f3_row0", fa[0], 8'h30);
    chk("col_f3_row1", fa[1], 8'h02);
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("col_f4", fa[0], 8'h30);
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("col_f5_row0", fa[0], 8'h60);
    chk("col_f5_row1", fa[1], 8'h04);
    scroll_en = 1'b0;

    // Asynchronous reset mid-frame with a commit pending
    do_reset;
    row_sel = 3'd0;
    step;
    row_sel = 3'd1; wr_en = 1'b1; wr_row = 3'd2; wr_data = 8'h5A; commit = 1'b1;
    step;
    wr_en = 1'b0; commit = 1'b0;
    row_sel = 3'd2;
    step;
    chk("ar_pending_before", 8'(cp_a), 8'h01);
    chk("ar_data_before", rd_a, 8'h04);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_pending_async", 8'(cp_a), 8'h00);
    chk("ar_data_async", rd_a, 8'h00);
    chk("ar_pending_async_b", 8'(cp_b), 8'h00);
    step;
    rst = 1'b1;
    frame(1'b0, 3'd0, 8'h00, 1'b0);
    chk("ar_row2_init", fa[2], 8'h04);
    chk("ar_row0_init", fa[0], 8'h01);
    frame(1'b0, 3'd0, 8'h00, 1'b0);
    chk("ar_row2_no_swap", fa[2], 8'h04);
    chk("ar_pending_after", 8'(cp_a), 8'h00);

    // Blink request
    do_reset;
    blink = 1'b1;
`ifdef DOT_MATRIX_BLINK_EN
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("bl_f1", fa[3], 8'h08);
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("bl_f2", fa[7], 8'h80);
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("bl_f3_row0", fa[0], 8'h00);
    chk("bl_f3_row7", fa[7], 8'h00);
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("bl_f4", fa[4], 8'h00);
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("bl_f5", fa[0], 8'h01);
    blink = 1'b0;
    frame(1'b0, 3'd0, 8'h00, 1'b0);
    frame(1'b0, 3'd0, 8'h00, 1'b0); chk("bl_off", fa[5], 8'h20);
`else
    for (int f = 0; f < 4; f++) begin
      frame(1'b0, 3'd0, 8'h00, 1'b0);
      chk($sformatf("bl_ignored_f%0d_row0", f), fa[0], 8'h01);
      chk($sformatf("bl_ignored_f%0d_row5", f), fa[5], 8'h20);
    end
    blink = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
